// File: rtl/digit_mult_pkg.sv
`default_nettype none
// ============================================================================
// Module   : digit_mult_pkg
// Brief    : Shared types and helpers for the digit-serial multiplier.
// Revision : 1.0 - initial release
// ============================================================================
package digit_mult_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   function automatic int num_digits(input int width, input int digit);
      return width / digit;
   endfunction

   // Substitute product used for the all-ones digit pair in approximate mode.
   function automatic int APPROX_VAL(input int digit);
      return (1 << (2*digit - 1)) - 1;
   endfunction

endpackage
`default_nettype wire

// File: rtl/digit_serial_mult_if.sv
`default_nettype none
// ============================================================================
// Module   : digit_serial_mult_if
// Brief    : Operand and product valid/ready channels of digit_serial_mult.
// Revision : 1.0 - initial release
// ============================================================================
interface digit_serial_mult_if #(
   parameter int WIDTH = 8
);
   logic                 in_valid;
   logic                 in_ready;
   logic [WIDTH-1:0]     a;
   logic [WIDTH-1:0]     b;
   logic                 out_valid;
   logic                 out_ready;
   logic [2*WIDTH-1:0]   p;
   logic                 approx;

   modport master (
      output in_valid, a, b, out_ready,
      input  in_ready, out_valid, p, approx
   );

   modport slave (
      input  in_valid, a, b, out_ready,
      output in_ready, out_valid, p, approx
   );
endinterface
`default_nettype wire

// File: rtl/digit_mul_cell.sv
`default_nettype none
// ============================================================================
// Module   : digit_mul_cell
// Brief    : Combinational DIGIT x DIGIT multiplier cell; approximate variant
//            under MULT_APPROX_EN.
// Revision : 1.0 - initial release
// ============================================================================
module digit_mul_cell
   import digit_mult_pkg::*;
#(
   parameter int DIGIT = 2
)(
   input  logic [DIGIT-1:0]   da,
   input  logic [DIGIT-1:0]   db,
   output logic [2*DIGIT-1:0] prod,
   output logic               pair_approx
);

   logic [2*DIGIT-1:0] w_exact;

   assign w_exact = (2*DIGIT)'(da) * (2*DIGIT)'(db);

`ifdef MULT_APPROX_EN
   logic w_all_ones;

   assign w_all_ones  = (&da) & (&db);
   assign prod        = w_all_ones ? (2*DIGIT)'(APPROX_VAL(DIGIT)) : w_exact;
   assign pair_approx = w_all_ones;
`else
   assign prod        = w_exact;
   assign pair_approx = 1'b0;
`endif

endmodule
`default_nettype wire

// File: rtl/digit_serial_mult.sv
`default_nettype none
// ============================================================================
// Module   : digit_serial_mult
// Brief    : Digit-serial unsigned multiplier, one digit pair per cycle,
//            valid/ready on both sides. Optional macro: MULT_APPROX_EN.
// Revision : 1.0 - initial release
// ============================================================================
module digit_serial_mult
   import digit_mult_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int DIGIT = 2
)(
   input  logic               clk,
   input  logic               rst,
   digit_serial_mult_if.slave bus
);

   localparam int            N     = num_digits(WIDTH, DIGIT);
   localparam int            IW    = (N > 1) ? $clog2(N) : 1;
   localparam int            ACC_W = 2*WIDTH;
   localparam logic [IW-1:0] LAST  = IW'(N-1);

   generate
      if (WIDTH % DIGIT != 0) begin : g_bad_width
         $error("WIDTH must be a multiple of DIGIT");
      end
   endgenerate

   state_t             r_state;
   logic [WIDTH-1:0]   r_a;
   logic [WIDTH-1:0]   r_b;
   logic [IW-1:0]      r_i;
   logic [IW-1:0]      r_j;
   logic [ACC_W-1:0]   r_acc;
   logic               r_approx_seen;

   logic [DIGIT-1:0]   w_da;
   logic [DIGIT-1:0]   w_db;
   logic [2*DIGIT-1:0] w_prod;
   logic               w_pair_approx;
   logic [ACC_W-1:0]   w_acc_next;

   assign w_da = r_a[DIGIT*32'(r_i) +: DIGIT];
   assign w_db = r_b[DIGIT*32'(r_j) +: DIGIT];

   digit_mul_cell #(
      .DIGIT (DIGIT)
   ) u_cell (
      .da          (w_da),
      .db          (w_db),
      .prod        (w_prod),
      .pair_approx (w_pair_approx)
   );

   // Shift amount is formed at full integer width so i+j cannot wrap.
   assign w_acc_next = r_acc + (ACC_W'(w_prod) << (DIGIT*(32'(r_i) + 32'(r_j))));

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state       <= ST_IDLE;
         r_a           <= '0;
         r_b           <= '0;
         r_i           <= '0;
         r_j           <= '0;
         r_acc         <= '0;
         r_approx_seen <= 1'b0;
         bus.in_ready  <= 1'b1;
         bus.out_valid <= 1'b0;
         bus.p         <= '0;
         bus.approx    <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (bus.in_valid) begin
                  r_a           <= bus.a;
                  r_b           <= bus.b;
                  r_i           <= '0;
                  r_j           <= '0;
                  r_acc         <= '0;
                  r_approx_seen <= 1'b0;
                  bus.in_ready  <= 1'b0;
                  if ((bus.a == '0) || (bus.b == '0)) begin
                     r_state       <= ST_DONE;
                     bus.out_valid <= 1'b1;
                     bus.p         <= '0;
                     bus.approx    <= 1'b0;
                  end else begin
                     r_state <= ST_BUSY;
                  end
               end
            end

            ST_BUSY: begin
               r_acc         <= w_acc_next;
               r_approx_seen <= r_approx_seen | w_pair_approx;
               if (r_j == LAST) begin
                  r_j <= '0;
                  if (r_i == LAST) begin
                     r_state       <= ST_DONE;
                     bus.out_valid <= 1'b1;
                     bus.p         <= w_acc_next;
                     bus.approx    <= r_approx_seen | w_pair_approx;
                  end else begin
                     r_i <= r_i + IW'(1);
                  end
               end else begin
                  r_j <= r_j + IW'(1);
               end
            end

            ST_DONE: begin
               if (bus.out_ready) begin
                  r_state       <= ST_IDLE;
                  bus.out_valid <= 1'b0;
                  bus.in_ready  <= 1'b1;
               end
            end

            default: begin
               r_state       <= ST_IDLE;
               bus.in_ready  <= 1'b1;
               bus.out_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_digit_serial_mult.sv
`default_nettype none
// ============================================================================
// Module   : tb_digit_serial_mult
// Brief    : Directed self-checking bench for digit_serial_mult (8/2 and 16/4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_digit_serial_mult;

   logic clk;
   logic rst;
   int   n_checks;
   int   n_errors;

   digit_serial_mult_if #(.WIDTH(8))  bus8 ();
   digit_serial_mult_if #(.WIDTH(16)) bus16 ();

   digit_serial_mult #(.WIDTH(8), .DIGIT(2)) dut8 (
      .clk (clk),
      .rst (rst),
      .bus (bus8)
   );

   digit_serial_mult #(.WIDTH(16), .DIGIT(4)) dut16 (
      .clk (clk),
      .rst (rst),
      .bus (bus16)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      n_checks++;
      if (observed !== expected) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
      end
   endtask

   task automatic issue8(input logic [7:0] a, input logic [7:0] b);
      @(negedge clk);
      bus8.a        = a;
      bus8.b        = b;
      bus8.in_valid = 1'b1;
      check("issue8_in_ready", 32'(bus8.in_ready), 32'd1);
      @(posedge clk);
      #1;
      bus8.in_valid = 1'b0;
      bus8.a        = ~a;
      bus8.b        = ~b;
   endtask

   task automatic await8(input string tag, input int exp_lat, input logic [15:0] exp_p,
                         input logic exp_approx);
      int lat;
      lat = 1;
      @(negedge clk);
      while (!bus8.out_valid && lat < 40) begin
         check({tag, "_busy_in_ready"}, 32'(bus8.in_ready), 32'd0);
         lat++;
         @(negedge clk);
      end
      check({tag, "_latency"},  32'(lat),            32'(exp_lat));
      check({tag, "_p"},        32'(bus8.p),         32'(exp_p));
      check({tag, "_approx"},   32'(bus8.approx),    32'(exp_approx));
      check({tag, "_in_ready"}, 32'(bus8.in_ready),  32'd0);
   endtask

   task automatic release8(input string tag);
      bus8.out_ready = 1'b1;
      @(negedge clk);
      check({tag, "_out_valid_low"}, 32'(bus8.out_valid), 32'd0);
      check({tag, "_in_ready_high"}, 32'(bus8.in_ready),  32'd1);
   endtask

   task automatic run16(input string tag, input logic [15:0] a, input logic [15:0] b,
                        input logic [31:0] exp_p, input int exp_lat);
      int lat;
      bus16.out_ready = 1'b1;
      @(negedge clk);
      bus16.a        = a;
      bus16.b        = b;
      bus16.in_valid = 1'b1;
      check({tag, "_in_ready"}, 32'(bus16.in_ready), 32'd1);
      @(posedge clk);
      #1;
      bus16.in_valid = 1'b0;
      bus16.a        = ~a;
      bus16.b        = ~b;
      lat = 1;
      @(negedge clk);
      while (!bus16.out_valid && lat < 40) begin
         lat++;
         @(negedge clk);
      end
      check({tag, "_latency"}, 32'(lat),     32'(exp_lat));
      check({tag, "_p"},       bus16.p,      exp_p);
      check({tag, "_approx"},  32'(bus16.approx), 32'd0);
      @(negedge clk);
      check({tag, "_out_valid_low"}, 32'(bus16.out_valid), 32'd0);
   endtask

   initial begin
      n_checks        = 0;
      n_errors        = 0;
      rst             = 1'b1;
      bus8.in_valid   = 1'b0;
      bus8.a          = '0;
      bus8.b          = '0;
      bus8.out_ready  = 1'b1;
      bus16.in_valid  = 1'b0;
      bus16.a         = '0;
      bus16.b         = '0;
      bus16.out_ready = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_in_ready",  32'(bus8.in_ready),  32'd1);
      check("rst_out_valid", 32'(bus8.out_valid), 32'd0);
      check("rst_p",         32'(bus8.p),         32'd0);
      check("rst_approx",    32'(bus8.approx),    32'd0);
      check("rst16_p",       bus16.p,             32'd0);
      rst = 1'b0;

      // Basic product, out_ready held high
      issue8(8'hC8, 8'h0F);
      await8("c8x0f", 17, 16'h0BB8, 1'b0);
      release8("c8x0f");

      // Zero operand short-cuts straight to DONE
      issue8(8'h00, 8'hFF);
      await8("zero_a", 1, 16'h0000, 1'b0);
      release8("zero_a");
      issue8(8'h5A, 8'h00);
      await8("zero_b", 1, 16'h0000, 1'b0);
      release8("zero_b");

      // All-ones operands
      issue8(8'hFF, 8'hFF);
`ifdef MULT_APPROX_EN
      await8("ffxff", 17, 16'hC58F, 1'b1);
`else
      await8("ffxff", 17, 16'hFE01, 1'b0);
`endif
      release8("ffxff");

      // Backpressure in DONE; flag from previous op must be cleared
      bus8.out_ready = 1'b0;
      issue8(8'h12, 8'h21);
      await8("bp", 17, 16'h0252, 1'b0);
      bus8.in_valid = 1'b1;
      bus8.a        = 8'h05;
      bus8.b        = 8'h05;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         check("bp_hold_p",         32'(bus8.p),         32'h0252);
         check("bp_hold_out_valid", 32'(bus8.out_valid), 32'd1);
         check("bp_hold_in_ready",  32'(bus8.in_ready),  32'd0);
      end
      bus8.in_valid = 1'b0;
      release8("bp");
      @(negedge clk);
      check("bp_no_stray_op", 32'(bus8.out_valid), 32'd0);

      // Reset mid-BUSY discards the operation
      issue8(8'hFF, 8'h7F);
      repeat (6) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check("midrst_out_valid", 32'(bus8.out_valid), 32'd0);
      check("midrst_p",         32'(bus8.p),         32'd0);
      check("midrst_in_ready",  32'(bus8.in_ready),  32'd1);
      rst = 1'b0;
      issue8(8'h03, 8'h03);
      await8("post_rst", 17, 16'h0009, 1'b0);
      release8("post_rst");

      // Wider configuration
      run16("w16_a", 16'h1234, 16'h5678, 32'h0626_0060, 17);
      run16("w16_z", 16'h0000, 16'hBEEF, 32'h0000_0000, 1);
`ifndef MULT_APPROX_EN
      run16("w16_ff", 16'hFFFF, 16'hFFFF, 32'hFFFE_0001, 17);
      for (int k = 0; k < 40; k++) begin
         logic [7:0] ra;
         logic [7:0] rb;
         ra = 8'($urandom_range(0, 255));
         rb = 8'($urandom_range(0, 255));
         issue8(ra, rb);
         await8("rnd8", ((ra == 8'd0) || (rb == 8'd0)) ? 1 : 17, 16'(ra) * 16'(rb), 1'b0);
         release8("rnd8");
      end
      for (int k = 0; k < 40; k++) begin
         logic [15:0] wa;
         logic [15:0] wb;
         wa = 16'($urandom_range(1, 65535));
         wb = 16'($urandom_range(1, 65535));
         run16("rnd16", wa, wb, 32'(wa) * 32'(wb), 17);
      end
`endif

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog expired");
   end

endmodule
`default_nettype wire
